// File: rtl/lint32_to_axi_bridge.sv
// lint32_to_axi_bridge
// Converts 32-bit TCDM/LINT slave requests into single-beat AXI4 master
// transactions. Responses return on the TCDM response channel in request
// order. Read and write requests are never outstanding together, because
// AXI orders only within R and within B for a single ID.
//
// Optional feature macro: LINT32_TO_AXI_ERR_OPC_EN
//   defined   : o_tcdm_r_opc = resp[1] (SLVERR/DECERR report 1)
//   undefined : o_tcdm_r_opc tied 0, AXI resp ignored
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   i_tcdm_*                 TCDM request: req, add, wen (0 = write), wdata, be
//   o_tcdm_gnt               combinational grant
//   o_tcdm_r_*               response: valid (1-cycle pulse), rdata, opc
//   o_axi_aw_* / i_axi_aw_*  AXI write address channel
//   o_axi_w_*  / i_axi_w_*   AXI write data channel
//   i_axi_b_*  / o_axi_b_*   AXI write response channel
//   o_axi_ar_* / i_axi_ar_*  AXI read address channel
//   i_axi_r_*  / o_axi_r_*   AXI read data channel
module lint32_to_axi_bridge #(
  parameter int unsigned AXI_ID_WIDTH    = 1,
  parameter int unsigned AXI_USER_WIDTH  = 6,
  parameter int unsigned AXI_ID_VALUE    = 0,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // TCDM slave side
  input  logic                      i_tcdm_req,
  input  logic [31:0]               i_tcdm_add,
  input  logic                      i_tcdm_wen,
  input  logic [31:0]               i_tcdm_wdata,
  input  logic [3:0]                i_tcdm_be,
  output logic                      o_tcdm_gnt,
  output logic                      o_tcdm_r_valid,
  output logic [31:0]               o_tcdm_r_rdata,
  output logic                      o_tcdm_r_opc,
  // AXI AW
  output logic [AXI_ID_WIDTH-1:0]   o_axi_aw_id,
  output logic [31:0]               o_axi_aw_addr,
  output logic [7:0]                o_axi_aw_len,
  output logic [2:0]                o_axi_aw_size,
  output logic [1:0]                o_axi_aw_burst,
  output logic                      o_axi_aw_lock,
  output logic [3:0]                o_axi_aw_cache,
  output logic [2:0]                o_axi_aw_prot,
  output logic [3:0]                o_axi_aw_qos,
  output logic [3:0]                o_axi_aw_region,
  output logic [5:0]                o_axi_aw_atop,
  output logic [AXI_USER_WIDTH-1:0] o_axi_aw_user,
  output logic                      o_axi_aw_valid,
  input  logic                      i_axi_aw_ready,
  // AXI W
  output logic [31:0]               o_axi_w_data,
  output logic [3:0]                o_axi_w_strb,
  output logic                      o_axi_w_last,
  output logic [AXI_USER_WIDTH-1:0] o_axi_w_user,
  output logic                      o_axi_w_valid,
  input  logic                      i_axi_w_ready,
  // AXI B
  input  logic [AXI_ID_WIDTH-1:0]   i_axi_b_id,
  input  logic [1:0]                i_axi_b_resp,
  input  logic [AXI_USER_WIDTH-1:0] i_axi_b_user,
  input  logic                      i_axi_b_valid,
  output logic                      o_axi_b_ready,
  // AXI AR
  output logic [AXI_ID_WIDTH-1:0]   o_axi_ar_id,
  output logic [31:0]               o_axi_ar_addr,
  output logic [7:0]                o_axi_ar_len,
  output logic [2:0]                o_axi_ar_size,
  output logic [1:0]                o_axi_ar_burst,
  output logic                      o_axi_ar_lock,
  output logic [3:0]                o_axi_ar_cache,
  output logic [2:0]                o_axi_ar_prot,
  output logic [3:0]                o_axi_ar_qos,
  output logic [3:0]                o_axi_ar_region,
  output logic [AXI_USER_WIDTH-1:0] o_axi_ar_user,
  output logic                      o_axi_ar_valid,
  input  logic                      i_axi_ar_ready,
  // AXI R
  input  logic [AXI_ID_WIDTH-1:0]   i_axi_r_id,
  input  logic [31:0]               i_axi_r_data,
  input  logic [1:0]                i_axi_r_resp,
  input  logic                      i_axi_r_last,
  input  logic [AXI_USER_WIDTH-1:0] i_axi_r_user,
  input  logic                      i_axi_r_valid,
  output logic                      o_axi_r_ready
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [AXI_ID_WIDTH-1:0] LP_ID = AXI_ID_WIDTH'(AXI_ID_VALUE);

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_e;

  dir_e             r_dir;
  logic [CNT_W-1:0] r_count;
  logic             r_aw_valid;
  logic             r_w_valid;
  logic             r_ar_valid;
  logic [31:0]      r_aw_addr;
  logic [31:0]      r_ar_addr;
  logic [31:0]      r_w_data;
  logic [3:0]       r_w_strb;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_opc;

  dir_e             w_req_dir;
  logic             w_issue_empty;
  logic             w_gnt;
  logic             w_r_hs;
  logic             w_b_hs;
  logic             w_rsp;
  logic             w_r_err;
  logic             w_b_err;
  logic             w_unused;

  // Fields the bridge never consumes.
  assign w_unused = ^{i_axi_b_id, i_axi_b_user, i_axi_b_resp,
                      i_axi_r_id, i_axi_r_last, i_axi_r_user, i_axi_r_resp};

`ifdef LINT32_TO_AXI_ERR_OPC_EN
  assign w_r_err = i_axi_r_resp[1];
  assign w_b_err = i_axi_b_resp[1];
`else
  assign w_r_err = 1'b0;
  assign w_b_err = 1'b0;
`endif

  assign w_req_dir     = i_tcdm_wen ? DIR_READ : DIR_WRITE;
  assign w_issue_empty = ~(r_aw_valid | r_w_valid | r_ar_valid);

  // A request of the opposite direction waits until every outstanding
  // transaction has answered, which keeps TCDM responses in order.
  assign w_gnt = i_tcdm_req & w_issue_empty & (r_count < LP_MAX) &
                 ((r_count == '0) | (w_req_dir == r_dir));

  // Ready is held high on R and B, so valid alone is the handshake.
  assign w_r_hs = i_axi_r_valid;
  assign w_b_hs = i_axi_b_valid;
  // Responses with nothing outstanding are protocol violations; drop them.
  assign w_rsp  = (w_r_hs | w_b_hs) & (r_count != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_dir       <= DIR_READ;
      r_count     <= '0;
      r_aw_valid  <= 1'b0;
      r_w_valid   <= 1'b0;
      r_ar_valid  <= 1'b0;
      r_aw_addr   <= '0;
      r_ar_addr   <= '0;
      r_w_data    <= '0;
      r_w_strb    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_opc   <= 1'b0;
    end else begin
      // Grant requires an empty issue stage, so a load never collides
      // with a handshake clear of the same register.
      if (r_aw_valid && i_axi_aw_ready) r_aw_valid <= 1'b0;
      if (r_w_valid && i_axi_w_ready)   r_w_valid  <= 1'b0;
      if (r_ar_valid && i_axi_ar_ready) r_ar_valid <= 1'b0;

      if (w_gnt) begin
        r_dir <= w_req_dir;
        if (!i_tcdm_wen) begin
          r_aw_addr  <= i_tcdm_add;
          r_w_data   <= i_tcdm_wdata;
          r_w_strb   <= i_tcdm_be;
          r_aw_valid <= 1'b1;
          r_w_valid  <= 1'b1;
        end else begin
          r_ar_addr  <= i_tcdm_add;
          r_ar_valid <= 1'b1;
        end
      end

      unique case ({w_gnt, w_rsp})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      r_rsp_valid <= w_rsp;
      if (w_rsp) begin
        if (w_r_hs) begin
          r_rsp_rdata <= i_axi_r_data;
          r_rsp_opc   <= w_r_err;
        end else begin
          r_rsp_rdata <= '0;
          r_rsp_opc   <= w_b_err;
        end
      end
    end
  end

  // TCDM side
  assign o_tcdm_gnt     = w_gnt;
  assign o_tcdm_r_valid = r_rsp_valid;
  assign o_tcdm_r_rdata = r_rsp_rdata;
  assign o_tcdm_r_opc   = r_rsp_opc;

  // AW
  assign o_axi_aw_id     = LP_ID;
  assign o_axi_aw_addr   = r_aw_addr;
  assign o_axi_aw_len    = '0;
  assign o_axi_aw_size   = 3'd2;
  assign o_axi_aw_burst  = 2'b01;
  assign o_axi_aw_lock   = 1'b0;
  assign o_axi_aw_cache  = '0;
  assign o_axi_aw_prot   = '0;
  assign o_axi_aw_qos    = '0;
  assign o_axi_aw_region = '0;
  assign o_axi_aw_atop   = '0;
  assign o_axi_aw_user   = '0;
  assign o_axi_aw_valid  = r_aw_valid;

  // W
  assign o_axi_w_data  = r_w_data;
  assign o_axi_w_strb  = r_w_strb;
  assign o_axi_w_last  = 1'b1;
  assign o_axi_w_user  = '0;
  assign o_axi_w_valid = r_w_valid;

  // AR
  assign o_axi_ar_id     = LP_ID;
  assign o_axi_ar_addr   = r_ar_addr;
  assign o_axi_ar_len    = '0;
  assign o_axi_ar_size   = 3'd2;
  assign o_axi_ar_burst  = 2'b01;
  assign o_axi_ar_lock   = 1'b0;
  assign o_axi_ar_cache  = '0;
  assign o_axi_ar_prot   = '0;
  assign o_axi_ar_qos    = '0;
  assign o_axi_ar_region = '0;
  assign o_axi_ar_user   = '0;
  assign o_axi_ar_valid  = r_ar_valid;

  // Responses
  assign o_axi_b_ready = 1'b1;
  assign o_axi_r_ready = 1'b1;

endmodule
